// File: rtl/ps2_paddle_keys.sv
// PS/2 keyboard receiver and scan-code decoder.
// Drives held up/down levels for two paddles.
module ps2_paddle_keys #(
  parameter logic [19:0] TIMEOUT_COUNT = 20'd100000,
  parameter logic [7:0]  KEY_P1_UP     = 8'h1D,
  parameter logic [7:0]  KEY_P1_DOWN   = 8'h1B,
  parameter logic [7:0]  KEY_P2_UP     = 8'h75,
  parameter logic [7:0]  KEY_P2_DOWN   = 8'h72
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic       p1_up,
  output logic       p1_down,
  output logic       p2_up,
  output logic       p2_down,
  output logic       scan_valid,
  output logic [7:0] scan_code,
  output logic       rx_error
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t      state, state_nx;
  logic        s1_clk, s2_clk, prev_clk;
  logic        s1_dat, s2_dat;
  logic        fall;
  logic [19:0] tcount;
  logic [7:0]  shift, shift_nx;
  logic [2:0]  bit_cnt, bit_cnt_nx;
  logic        par, par_nx;
  logic        byte_ok, frame_err, timeout;
  logic        ext, ext_nx, brk, brk_nx;
  logic [3:0]  keys_nx;

  assign fall = prev_clk & ~s2_clk;

  // Two-flop synchronisers; pins idle high so they reset high.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_clk   <= 1'b1;
      s2_clk   <= 1'b1;
      prev_clk <= 1'b1;
      s1_dat   <= 1'b1;
      s2_dat   <= 1'b1;
    end else begin
      s1_clk   <= ps2_clk;
      s2_clk   <= s1_clk;
      prev_clk <= s2_clk;
      s1_dat   <= ps2_dat;
      s2_dat   <= s1_dat;
    end
  end

  // Idle-gap counter: cleared by each fall, saturates at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      tcount <= '0;
    end else if (fall) begin
      tcount <= '0;
    end else if (state != S_IDLE && tcount != TIMEOUT_COUNT) begin
      tcount <= tcount + 20'd1;
    end
  end

  assign timeout = (state != S_IDLE) && !fall &&
                   (tcount == TIMEOUT_COUNT - 20'd1);

  // Receiver state and frame shift register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
    end else begin
      state   <= state_nx;
      shift   <= shift_nx;
      bit_cnt <= bit_cnt_nx;
      par     <= par_nx;
    end
  end

  // Frame sequencing on synchronised PS/2 clock falls.
  always_comb begin
    state_nx   = state;
    shift_nx   = shift;
    bit_cnt_nx = bit_cnt;
    par_nx     = par;
    byte_ok    = 1'b0;
    frame_err  = 1'b0;
    if (timeout) begin
      state_nx = S_IDLE;
    end else if (fall) begin
      unique case (state)
        S_IDLE: begin
          if (!s2_dat) begin
            state_nx   = S_DATA;
            bit_cnt_nx = '0;
          end
        end
        S_DATA: begin
          shift_nx   = {s2_dat, shift[7:1]};
          bit_cnt_nx = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_nx = S_PARITY;
        end
        S_PARITY: begin
          par_nx   = s2_dat;
          state_nx = S_STOP;
        end
        S_STOP: begin
          state_nx = S_IDLE;
          if (s2_dat && (^{shift, par})) byte_ok   = 1'b1;
          else                           frame_err = 1'b1;
        end
      endcase
    end
  end

  // Prefix flags and key table lookup for each good byte.
  always_comb begin
    ext_nx  = ext;
    brk_nx  = brk;
    keys_nx = {p1_up, p1_down, p2_up, p2_down};
    if (frame_err || timeout) begin
      ext_nx = 1'b0;
      brk_nx = 1'b0;
    end else if (byte_ok) begin
      unique case (1'b1)
        (shift == 8'hE0): ext_nx = 1'b1;
        (shift == 8'hF0): brk_nx = 1'b1;
        default: begin
          ext_nx = 1'b0;
          brk_nx = 1'b0;
          if (!ext && shift == KEY_P1_UP)   keys_nx[3] = ~brk;
          if (!ext && shift == KEY_P1_DOWN) keys_nx[2] = ~brk;
          if (ext && shift == KEY_P2_UP)    keys_nx[1] = ~brk;
          if (ext && shift == KEY_P2_DOWN)  keys_nx[0] = ~brk;
        end
      endcase
    end
  end

  // Registered outputs, flags and held key levels.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext        <= 1'b0;
      brk        <= 1'b0;
      p1_up      <= 1'b0;
      p1_down    <= 1'b0;
      p2_up      <= 1'b0;
      p2_down    <= 1'b0;
      scan_valid <= 1'b0;
      scan_code  <= '0;
      rx_error   <= 1'b0;
    end else begin
      ext        <= ext_nx;
      brk        <= brk_nx;
      {p1_up, p1_down, p2_up, p2_down} <= keys_nx;
      scan_valid <= byte_ok;
      rx_error   <= frame_err | timeout;
      if (byte_ok) scan_code <= shift;
    end
  end

endmodule

// File: tb/tb_ps2_paddle_keys.sv
// Bench for ps2_paddle_keys: bit-banged PS/2 frames
// checked against a prefix-queue key model.
module tb_ps2_paddle_keys;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       p1_up, p1_down, p2_up, p2_down;
  logic       scan_valid, rx_error;
  logic [7:0] scan_code;
  logic [3:0] keys;

  int checks = 0;
  int errors = 0;

  logic [7:0] sv_q[$];
  int         err_cnt = 0;
  int         both_cnt = 0;
  time        t_fall = 0;
  time        last_lat = 0;

  logic [3:0] mkeys = 4'b0;
  logic [7:0] pend[$];

  int         obs_n, obs_err;
  logic [7:0] obs_code;

  logic [7:0] kc[4] = '{8'h1D, 8'h1B, 8'h75, 8'h72};

  assign keys = {p1_up, p1_down, p2_up, p2_down};

  ps2_paddle_keys #(.TIMEOUT_COUNT(20'd20)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_dat    (ps2_dat),
    .p1_up      (p1_up),
    .p1_down    (p1_down),
    .p2_up      (p2_up),
    .p2_down    (p2_down),
    .scan_valid (scan_valid),
    .scan_code  (scan_code),
    .rx_error   (rx_error)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (scan_valid) begin
      sv_q.push_back(scan_code);
      last_lat = $time - t_fall;
    end
    if (rx_error) err_cnt++;
    if (scan_valid && rx_error) both_cnt++;
  end

  task automatic ps2_bit(input logic v);
    @(posedge clock); #1 ps2_dat = v;
    repeat (5) @(posedge clock);
    #1 ps2_clk = 1'b0;
    t_fall = $time;
    repeat (5) @(posedge clock);
    #1 ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ bad, b, 1'b0};
    for (int i = 0; i < 11; i++) ps2_bit(bits[i]);
  endtask

  // Key model: prefixes queue up until a terminal byte consumes them.
  task automatic model_byte(input logic [7:0] b, input bit bad);
    bit ext, brk;
    if (bad) begin
      pend.delete();
      return;
    end
    if (b == 8'hE0 || b == 8'hF0) begin
      pend.push_back(b);
      return;
    end
    ext = 0;
    brk = 0;
    foreach (pend[i]) begin
      if (pend[i] == 8'hE0) ext = 1;
      if (pend[i] == 8'hF0) brk = 1;
    end
    pend.delete();
    if (!ext && b == 8'h1D) mkeys[3] = !brk;
    if (!ext && b == 8'h1B) mkeys[2] = !brk;
    if (ext && b == 8'h75)  mkeys[1] = !brk;
    if (ext && b == 8'h72)  mkeys[0] = !brk;
  endtask

  task automatic do_byte(input logic [7:0] b, input bit bad);
    int n0, e0;
    n0 = sv_q.size();
    e0 = err_cnt;
    send_frame(b, bad);
    repeat (3) @(posedge clock);
    @(negedge clock);
    #1;
    obs_n = sv_q.size() - n0;
    obs_code = (obs_n > 0) ? sv_q[sv_q.size()-1] : 8'h00;
    obs_err = err_cnt - e0;
    model_byte(b, bad);
  endtask

  task automatic model_reset();
    mkeys = 4'b0;
    pend.delete();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    ps2_clk = 1'b1;
    ps2_dat = 1'b1;
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    model_reset();
    @(negedge clock);
    checks++;
    if ({keys, scan_valid, scan_code, rx_error} !== 13'b0) begin
      errors++;
      $display("FAIL reset_state: got keys=%b sv=%b code=%h err=%b want 0",
               keys, scan_valid, scan_code, rx_error);
    end
    do_byte(8'h1D, 0);
    checks++;
    if (obs_n !== 1 || obs_code !== 8'h1D || obs_err !== 0) begin
      errors++;
      $display("FAIL first_frame: n=%0d code=%h err=%0d want 1/1d/0",
               obs_n, obs_code, obs_err);
    end
    checks++;
    if (keys !== mkeys || keys !== 4'b1000) begin
      errors++;
      $display("FAIL first_keys: got %b want %b", keys, mkeys);
    end
    checks++;
    if (last_lat > 45) begin
      errors++;
      $display("FAIL latency: got %0t want <= 45", last_lat);
    end
  endtask

  task automatic test_p1_release();
    logic [7:0] seq[2] = '{8'hF0, 8'h1D};
    mkeys[2] = 1'b0;
    do_byte(8'h1B, 0);
    for (int i = 0; i < 2; i++) begin
      do_byte(seq[i], 0);
      checks++;
      if (obs_n !== 1 || obs_code !== seq[i] || obs_err !== 0) begin
        errors++;
        $display("FAIL p1_release_byte%0d: n=%0d code=%h want 1/%h",
                 i, obs_n, obs_code, seq[i]);
      end
    end
    checks++;
    if (keys !== mkeys || keys !== 4'b0100) begin
      errors++;
      $display("FAIL p1_release_keys: got %b want %b", keys, mkeys);
    end
  endtask

  task automatic test_p2_ext();
    logic [7:0] seq[6] = '{8'hE0, 8'h75, 8'hE0, 8'hF0, 8'h75, 8'h75};
    logic [3:0] want[6];
    want = '{4'b0100, 4'b0110, 4'b0110, 4'b0110, 4'b0100, 4'b0100};
    for (int i = 0; i < 6; i++) begin
      do_byte(seq[i], 0);
      checks++;
      if (obs_n !== 1 || obs_code !== seq[i] || keys !== want[i] ||
          keys !== mkeys) begin
        errors++;
        $display("FAIL p2_ext_%0d: n=%0d code=%h keys=%b want %h/%b",
                 i, obs_n, obs_code, keys, seq[i], want[i]);
      end
    end
  endtask

  task automatic test_parity_error();
    do_byte(8'hF0, 0);
    do_byte(8'h1B, 0);
    do_byte(8'h1B, 1);
    checks++;
    if (obs_n !== 0 || obs_err !== 1 || keys !== 4'b0000) begin
      errors++;
      $display("FAIL parity_err: n=%0d err=%0d keys=%b want 0/1/0000",
               obs_n, obs_err, keys);
    end
    do_byte(8'hF0, 0);
    do_byte(8'h1D, 1);
    do_byte(8'hE0, 0);
    do_byte(8'h72, 0);
    checks++;
    if (keys !== mkeys || keys !== 4'b0001) begin
      errors++;
      $display("FAIL parity_flags: got %b want %b", keys, mkeys);
    end
  endtask

  task automatic test_timeout();
    int e0, n0, k;
    time dt;
    e0 = err_cnt;
    n0 = sv_q.size();
    do_byte(8'hF0, 0);
    n0 = sv_q.size();
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    e0 = err_cnt;
    k = 0;
    while (err_cnt == e0 && k < 60) begin
      @(negedge clock);
      k++;
    end
    dt = $time - t_fall;
    checks++;
    if (err_cnt == e0 || dt < 220 || dt > 245) begin
      errors++;
      $display("FAIL timeout_delay: errs=%0d dt=%0t want 1 err at 220..245",
               err_cnt - e0, dt);
    end
    repeat (30) @(negedge clock);
    checks++;
    if (err_cnt - e0 !== 1 || sv_q.size() != n0) begin
      errors++;
      $display("FAIL timeout_once: errs=%0d bytes=%0d want 1/0",
               err_cnt - e0, sv_q.size() - n0);
    end
    model_byte(8'h00, 1);
    do_byte(8'h1B, 0);
    checks++;
    if (obs_n !== 1 || obs_code !== 8'h1B || keys !== mkeys ||
        keys !== 4'b0101) begin
      errors++;
      $display("FAIL timeout_recover: code=%h keys=%b want 1b/0101",
               obs_code, keys);
    end
  endtask

  task automatic test_reset_mid_frame();
    do_byte(8'h1D, 0);
    do_byte(8'h1B, 0);
    checks++;
    if (keys !== mkeys || keys[3:2] !== 2'b11) begin
      errors++;
      $display("FAIL simultaneous: got %b want %b", keys, mkeys);
    end
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    checks++;
    if ({keys, scan_code} !== 12'b0) begin
      errors++;
      $display("FAIL async_reset: keys=%b code=%h want 0", keys, scan_code);
    end
    model_reset();
    repeat (3) @(posedge clock);
    #2 reset_n = 1'b1;
    do_byte(8'h1B, 0);
    checks++;
    if (obs_n !== 1 || obs_code !== 8'h1B || keys !== mkeys ||
        keys !== 4'b0100) begin
      errors++;
      $display("FAIL after_reset: code=%h keys=%b want 1b/0100",
               obs_code, keys);
    end
  endtask

  task automatic test_random();
    logic [7:0] sb[$];
    bit         sbad[$];
    logic [7:0] r;
    int         op, k;
    for (int it = 0; it < 30; it++) begin
      sb.delete();
      sbad.delete();
      op = $urandom_range(0, 5);
      k = $urandom_range(0, 3);
      case (op)
        0, 2: begin
          for (int j = 0; j <= (op == 2 ? 1 : 0); j++) begin
            if (k >= 2) begin sb.push_back(8'hE0); sbad.push_back(0); end
            sb.push_back(kc[k]); sbad.push_back(0);
          end
        end
        1: begin
          if (k >= 2) begin sb.push_back(8'hE0); sbad.push_back(0); end
          sb.push_back(8'hF0); sbad.push_back(0);
          sb.push_back(kc[k]); sbad.push_back(0);
        end
        3: begin
          r = 8'($urandom);
          if (r == 8'hE0 || r == 8'hF0) r = 8'h00;
          sb.push_back(r); sbad.push_back(0);
        end
        4: begin
          if (k < 2) begin sb.push_back(8'hE0); sbad.push_back(0); end
          if ($urandom_range(0, 1) == 1) begin
            sb.push_back(8'hF0); sbad.push_back(0);
          end
          sb.push_back(kc[k]); sbad.push_back(0);
        end
        default: begin
          sb.push_back($urandom_range(0, 1) ? 8'hE0 : 8'hF0);
          sbad.push_back(0);
          sb.push_back(8'($urandom)); sbad.push_back(1);
          sb.push_back(kc[k]); sbad.push_back(0);
        end
      endcase
      foreach (sb[j]) begin
        do_byte(sb[j], sbad[j]);
        checks++;
        if (sbad[j] ? (obs_n !== 0 || obs_err !== 1)
                    : (obs_n !== 1 || obs_code !== sb[j] ||
                       obs_err !== 0 || last_lat > 45)) begin
          errors++;
          $display("FAIL rand_frame it%0d: byte=%h bad=%0d n=%0d code=%h err=%0d",
                   it, sb[j], sbad[j], obs_n, obs_code, obs_err);
        end
        checks++;
        if (keys !== mkeys) begin
          errors++;
          $display("FAIL rand_keys it%0d: got %b want %b", it, keys, mkeys);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_p1_release();
    test_p2_ext();
    test_parity_error();
    test_timeout();
    test_reset_mid_frame();
    test_random();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL exclusive: got %0d overlap cycles want 0", both_cnt);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_paddle_keys.md
Name: ps2_paddle_keys

Overview:
- Upstream input stage for the paddle location processors.
- Receives PS/2 keyboard frames and decodes make, break and extended scan-code sequences.
- Drives held up/down key levels for two paddles: player 1 on W/S, player 2 on the arrow keys.
- Also exposes each raw decoded byte as a one-cycle strobe, for debug and for future menu logic.

Parameters:
- TIMEOUT_COUNT, 20'd100000: system clocks without a PS/2 falling edge before a partial frame is abandoned (2 ms at 50 MHz).
- KEY_P1_UP, 8'h1D: W scan code, non-extended.
- KEY_P1_DOWN, 8'h1B: S scan code, non-extended.
- KEY_P2_UP, 8'h75: Up-arrow scan code, requires E0 prefix.
- KEY_P2_DOWN, 8'h72: Down-arrow scan code, requires E0 prefix.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset; one clock, reset is asynchronous and active-low.
- ps2_clk  in  1  raw PS/2 clock pin, asynchronous.
- ps2_dat  in  1  raw PS/2 data pin, asynchronous.
- p1_up  out  1  held high while the P1 up key is pressed.
- p1_down  out  1  held high while the P1 down key is pressed.
- p2_up  out  1  held high while the P2 up key is pressed.
- p2_down  out  1  held high while the P2 down key is pressed.
- scan_valid  out  1  one-cycle pulse: a good data byte was received.
- scan_code  out  8  last good byte; valid while scan_valid is high, held otherwise.
- rx_error  out  1  one-cycle pulse: parity, start or stop error, or timeout.

Behaviour:
- Reset:
  - All outputs are 0: scan_code=8'h00, all key levels 0, both pulses 0.
  - Receiver goes to S_IDLE; ext and brk flags clear; timeout counter 0.
  - Reset asserted mid-frame discards the partial frame and drops all held keys.
- Input sync:
  - ps2_clk and ps2_dat each pass through 2 flops (s1, s2); a third flop holds the previous s2 of the clock.
  - fall = prev & ~s2_clk.
  - All frame sampling uses s2_dat in the cycle where fall=1.
- Receiver FSM, sampling on fall only:
  - S_IDLE: dat=0 -> S_DATA with bit count 0. dat=1 is ignored, no error.
  - S_DATA: shift in LSB first, 8 bits -> S_PARITY.
  - S_PARITY: capture the parity bit -> S_STOP.
  - S_STOP: dat=1 and odd parity over the 8 data bits plus the parity bit -> byte good. Otherwise -> error. Both cases return to S_IDLE.
- Timeout:
  - The counter clears on every fall and counts while the FSM is not in S_IDLE.
  - On reaching TIMEOUT_COUNT: rx_error pulses, FSM -> S_IDLE, ext and brk clear.
  - The counter saturates; it never wraps.
- Byte output timing:
  - The good-byte cycle is the clock edge after the cycle with the stop-bit fall.
  - On that edge: scan_valid=1 and scan_code=byte for exactly 1 cycle.
  - Key levels update on that same edge.
  - Pin-to-output latency is at most 4 clocks after the stop-bit falling edge.
- Decoder, on each good byte:
  - 8'hE0 -> set ext.
  - 8'hF0 -> set brk.
  - Any other byte -> if it matches a key table entry with a matching ext requirement, that key level = ~brk. Then clear ext and brk.
  - Non-matching bytes only clear the flags.
- Decode boundaries:
  - Non-extended 8'h75 (keypad 8) and 8'h72 do not affect player 2.
  - E0 1D and E0 1B do not affect player 1.
  - Typematic repeats (a repeated make) leave the level at 1.
  - Break of a key not held leaves it at 0.
  - Both up and down may be 1 at once; downstream resolves priority (down wins).
- Error frames: the byte is discarded, ext and brk clear, key levels are unchanged.
- Error and byte are mutually exclusive in a cycle. rx_error and scan_valid never assert together.

Test Plan:
- Reset check: hold reset_n=0 for 3 clocks, then release -> all outputs 0. The first frame 0x1D (bits 0,1,0,1,1,1,0,0,0,1,1) -> p1_up=1, scan_valid pulses once with scan_code=8'h1D.
- P1 release: send F0 then 1D -> p1_up=0 after the second frame. Two scan_valid pulses, 8'hF0 then 8'h1D. Other key levels unchanged.
- P2 extended vs keypad: send E0 75 -> p2_up=1. Send E0 F0 75 -> p2_up=0. Send bare 75 -> p2_up stays 0, scan_valid still pulses with 8'h75.
- Parity error: send 0x1B with parity bit 0 -> rx_error pulses 1 cycle, no scan_valid, p1_down stays 0. A following good E0 72 -> p2_down=1, which proves the flags were cleared.
- Timeout: with TIMEOUT_COUNT=20 in sim, send start plus 3 data bits, then stall -> rx_error pulses 20 clocks after the last fall and the FSM is idle. A following full 0x1B frame -> p1_down=1.
- Simultaneous and reset mid-frame: make 1D and make 1B -> p1_up=p1_down=1. Assert reset_n mid-way through the next frame -> both drop to 0 asynchronously. After release, the next clean frame decodes correctly.
